apb_gpio_irq: RTL
=================

// Module: apb_gpio_irq
// PURPOSE
//  Parametrised APB3 GPIO slave: NUM_PINS tristate pins with per-pin direction, synchronised
//  input sampling, atomic bit set/reset, and per-pin edge interrupts merged onto one irq line.
//  Sits on the RISC-V APB bus beside the other peripherals; irq feeds the core interrupt input.
// PARAMETERS
//  NUM_PINS     8   pin count, 1..16 (BSRR packs set/reset halves into 32 bits)
//  SYNC_STAGES  2   input synchroniser depth, >=2
// PORTS
//  PCLK     in    1         clock, all state on rising edge
//  PRESET   in    1         synchronous active-high reset
//  PADDR    in    32        byte address; decode PADDR[4:2], other bits ignored
//  PWRITE   in    1         1=write, 0=read
//  PENABLE  in    1         APB access phase
//  PWDATA   in    32        write data
//  PSEL     in    1         slave select
//  PRDATA   out   32        read data, registered
//  PREADY   out   1         transfer complete, registered
//  gpio     inout NUM_PINS  external pins
//  irq      out   1         level interrupt, OR of ISR bits
// BEHAVIOUR
//  Reset: every register, PRDATA, PREADY, irq, synchroniser and edge history = 0; all pins Hi-Z.
//  Handshake: access accepted when PSEL&PENABLE&!PREADY; next cycle PREADY=1 for exactly one
//   cycle (one wait state); write commits and PRDATA loads on the accepting edge. PREADY=0 otherwise.
//   Each transfer commits exactly once even if PSEL/PENABLE are held through the PREADY cycle.
//  Register map (offset: name, access):
//   0x00 MODER  RW  1=output driving ODR, 0=input (Hi-Z)
//   0x04 IDR    RO  synchronised pin level; writes ignored
//   0x08 ODR    RW  output data
//   0x0C BSRR   WO  bits[15:0] set ODR, bits[31:16] clear ODR; set wins per pin; reads 0
//   0x10 IER    RW  per-pin interrupt enable
//   0x14 RISE   RW  per-pin rising-edge detect enable
//   0x18 FALL   RW  per-pin falling-edge detect enable (RISE&FALL = both edges)
//   0x1C ISR    RW1C pending flags; write 1 clears, write 0 no effect
//  Bits >= NUM_PINS: read 0, writes discarded.
//  Input path: pin -> SYNC_STAGES flops -> IDR; prev = IDR delayed 1 cycle.
//   IDR latency: SYNC_STAGES cycles from pin change. Output pins read back their driven level.
//  Edge event: rise = IDR&~prev&RISE, fall = ~IDR&prev&FALL; event sets ISR bit in the cycle
//   after IDR changes, independent of IER (IER only masks irq).
//  irq = |(ISR & IER), registered, one cycle after ISR update.
//  Simultaneous ISR W1C and new event on same bit: set wins (no lost edge).
//  MODER change to input mid-run: pin goes Hi-Z same cycle; edges from resolving external level
//   are detected normally. ISR stays set while IER cleared; re-enabling IER raises irq.
//  Reset mid-transfer: PREADY drops to 0 next edge, partial write discarded; master retries.
// STRUCTURE
//  gpio_pkg: register offset localparams (GPIO_MODER..GPIO_ISR), MAX_PINS=16, addr index width.
//  Sub-module gpio_sync_edge: NUM_PINS-wide synchroniser + prev register + rise/fall pulses.
//  Top holds APB decode, register file, ISR set/clear, irq flop, per-pin tristate assign.
// TESTING
//  Reset then read all 8 offsets -> PRDATA 0, gpio Hi-Z, irq 0, PREADY one cycle per read.
//  MODER=0xFF, ODR=0xA5 -> gpio=0xA5; BSRR=0x00FF_0003 -> ODR=0x03 (set wins on bits 0,1).
//  MODER=0, drive gpio[2] 0->1 -> IDR bit2=1 after SYNC_STAGES cycles; no irq with IER=0.
//  RISE=0x04, IER=0x04, pulse gpio[2] -> ISR=0x04, irq=1; write ISR=0x04 -> irq=0 next cycle.
//  RISE=FALL=0x01, edge on pin0 same cycle as ISR=0x01 W1C -> ISR bit0 stays 1.
//  Hold PSEL/PENABLE after PREADY on ODR write -> single commit; PRESET mid-access -> all zero.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared register map and sizing for the APB GPIO block.
// Offsets are word indices decoded from PADDR[4:2].
package gpio_pkg;
    localparam int MAX_PINS   = 16;
    localparam int ADDR_IDX_W = 3;

    typedef logic [ADDR_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t GPIO_MODER = 3'd0;
    localparam reg_idx_t GPIO_IDR   = 3'd1;
    localparam reg_idx_t GPIO_ODR   = 3'd2;
    localparam reg_idx_t GPIO_BSRR  = 3'd3;
    localparam reg_idx_t GPIO_IER   = 3'd4;
    localparam reg_idx_t GPIO_RISE  = 3'd5;
    localparam reg_idx_t GPIO_FALL  = 3'd6;
    localparam reg_idx_t GPIO_ISR   = 3'd7;
endpackage

// File: rtl/gpio_sync_edge.sv
// Pin synchroniser with one-cycle history and qualified rise/fall event pulses.
// Latency: SYNC_STAGES cycles pin->idr, events valid the cycle after idr changes.
// Backpressure: none, free-running every cycle.
module gpio_sync_edge #(
    parameter int NUM_PINS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [NUM_PINS-1:0] pin_in,
    input  logic [NUM_PINS-1:0] rise_en,
    input  logic [NUM_PINS-1:0] fall_en,
    output logic [NUM_PINS-1:0] idr,
    output logic [NUM_PINS-1:0] rise_evt,
    output logic [NUM_PINS-1:0] fall_evt
);
    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] prev;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign idr      = sync_q[SYNC_STAGES-1];
    assign rise_evt =  idr & ~prev & rise_en;
    assign fall_evt = ~idr &  prev & fall_en;
endmodule

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO slave: per-pin direction, atomic set/reset, edge interrupts merged onto irq.
// Latency: one wait state per transfer; PRDATA and irq are registered.
// Backpressure: PREADY is low except for the single cycle after each accepted access.
module apb_gpio_irq
    import gpio_pkg::*;
#(
    parameter int NUM_PINS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [31:0]         PADDR,
    input  logic                PWRITE,
    input  logic                PENABLE,
    input  logic [31:0]         PWDATA,
    input  logic                PSEL,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    inout  wire  [NUM_PINS-1:0] gpio,
    output logic                irq
);
    logic [NUM_PINS-1:0] moder, odr, ier, rise, fall, isr;
    logic [NUM_PINS-1:0] idr, rise_evt, fall_evt;
    logic [NUM_PINS-1:0] wdat, bsrr_set, bsrr_clr, isr_clr, rd_bits;
    reg_idx_t            idx;
    logic                accept, wr;
    logic                unused_apb;

    // PREADY gates acceptance so a transfer held through its ready cycle commits once.
    assign accept   = PSEL & PENABLE & ~PREADY;
    assign wr       = accept & PWRITE;
    assign idx      = PADDR[4:2];
    assign wdat     = PWDATA[NUM_PINS-1:0];
    assign bsrr_set = PWDATA[NUM_PINS-1:0];
    assign bsrr_clr = PWDATA[16 +: NUM_PINS];
    assign isr_clr  = (wr && (idx == GPIO_ISR)) ? wdat : '0;

    assign unused_apb = ^{PADDR[31:5], PADDR[1:0], PWDATA};

    gpio_sync_edge #(
        .NUM_PINS    (NUM_PINS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .pin_in   (gpio),
        .rise_en  (rise),
        .fall_en  (fall),
        .idr      (idr),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt)
    );

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pad
        assign gpio[i] = moder[i] ? odr[i] : 1'bz;
    end

    always_comb begin
        rd_bits = '0;
        case (idx)
            GPIO_MODER: rd_bits = moder;
            GPIO_IDR:   rd_bits = idr;
            GPIO_ODR:   rd_bits = odr;
            GPIO_IER:   rd_bits = ier;
            GPIO_RISE:  rd_bits = rise;
            GPIO_FALL:  rd_bits = fall;
            GPIO_ISR:   rd_bits = isr;
            default:    rd_bits = '0;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            moder  <= '0;
            odr    <= '0;
            ier    <= '0;
            rise   <= '0;
            fall   <= '0;
            isr    <= '0;
            PRDATA <= '0;
            PREADY <= 1'b0;
            irq    <= 1'b0;
        end else begin
            PREADY <= accept;
            irq    <= |(isr & ier);
            if (accept && !PWRITE) PRDATA <= {{(32-NUM_PINS){1'b0}}, rd_bits};
            // New events are OR'd after the clear so a coincident edge is never lost.
            isr <= (isr & ~isr_clr) | rise_evt | fall_evt;
            if (wr) begin
                case (idx)
                    GPIO_MODER: moder <= wdat;
                    GPIO_ODR:   odr   <= wdat;
                    GPIO_BSRR:  odr   <= (odr & ~bsrr_clr) | bsrr_set;
                    GPIO_IER:   ier   <= wdat;
                    GPIO_RISE:  rise  <= wdat;
                    GPIO_FALL:  fall  <= wdat;
                    default:    ;
                endcase
            end
        end
    end
endmodule
